// File: rtl/mac_rx_pkg.sv
// Shared types and helpers for the MAC receive deframer.
//   deframer_state_t : FSM states of the header/payload/discard walker
//   mac_hdr_t        : header beat layout {seq, len, sync}
//   SYNC_WORD_DEFAULT: expected header sync value
//   calc_tkeep       : byte enables for the final payload beat
`timescale 1ns/1ps
package mac_rx_pkg;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DISCARD = 2'd2
  } deframer_state_t;

  typedef struct packed {
    logic [15:0] seq;
    logic [15:0] len;
    logic [31:0] sync;
  } mac_hdr_t;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h5A5A_C3C3;

  // Only len % 8 matters: a multiple of 8 fills the whole last beat.
  function automatic logic [7:0] calc_tkeep(input logic [2:0] len_mod8);
    logic [7:0] keep;
    if (len_mod8 == 3'd0) keep = 8'hFF;
    else                  keep = (8'h01 << len_mod8) - 8'h01;
    return keep;
  endfunction

endpackage

// File: rtl/mac_deframer_if.sv
// 64-bit AXI-Stream bundle used on both sides of the deframer.
//   tvalid/tdata/tkeep/tlast : driven by the master
//   tready                   : driven by the slave
`timescale 1ns/1ps
interface mac_deframer_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/mac_rx_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   wr_en/wr_data : push (ignored when full)
//   rd_en/rd_data : pop (ignored when empty); rd_data shows the head entry
//   count, empty  : current occupancy
`timescale 1ns/1ps
module mac_rx_fifo #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          wr_ok;
  logic          rd_ok;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/mac_deframer.sv
// MAC receive deframer: validates block headers, strips padding and
// forwards the payload as a byte-accurate AXI-Stream through a FWFT FIFO.
//   clk, reset_n   : clock, asynchronous active-low reset
//   s_axis_input   : block beats from the deblocker (never stalled)
//   m_axis_output  : payload stream with tkeep/tlast
//   frame_ok_cnt   : frames fully forwarded (wraps)
//   frame_drop_cnt : frames discarded or truncated (wraps)
//   hdr_err        : 1-cycle pulse on header rejection
//   seq_gap        : 1-cycle pulse on unexpected sequence number
`timescale 1ns/1ps
module mac_deframer
  import mac_rx_pkg::*;
#(
  parameter int          RS_CNT     = 236,
  parameter int          FIFO_DEPTH = 512,
  parameter logic [31:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mac_deframer_if.slave         s_axis_input,
  mac_deframer_if.master        m_axis_output,
  output logic [15:0]           frame_ok_cnt,
  output logic [15:0]           frame_drop_cnt,
  output logic                  hdr_err,
  output logic                  seq_gap
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  deframer_state_t state_q, state_d;
  logic [13:0]     rem_q, rem_d;
  logic [7:0]      last_keep_q, last_keep_d;
  logic [15:0]     exp_seq_q, exp_seq_d;
  logic [15:0]     ok_cnt_q, ok_cnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            hdr_err_q, hdr_err_d;
  logic            seq_gap_q, seq_gap_d;
  logic            tready_q;

  mac_hdr_t        hdr;
  logic [16:0]     len_plus7;
  logic [13:0]     nbeats;
  logic            beat;
  logic            hdr_good;
  logic [31:0]     free_entries;
  logic [CW-1:0]   occ_after;

  logic            wr_en;
  logic [7:0]      wr_keep;
  logic            wr_last;
  logic [72:0]     rd_data;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            rd_fire;
  logic            unused_in_keep;

  assign unused_in_keep = ^s_axis_input.tkeep;

  assign hdr       = s_axis_input.tdata;
  assign beat      = s_axis_input.tvalid && tready_q;
  assign len_plus7 = {1'b0, hdr.len} + 17'd7;
  assign nbeats    = len_plus7[16:3];
  assign rd_fire   = m_axis_output.tvalid && m_axis_output.tready;

  // Admission looks at occupancy after this cycle's pop, so a draining FIFO
  // is credited with the entry leaving on the same edge.
  assign occ_after    = fifo_count - CW'(rd_fire);
  assign free_entries = 32'(FIFO_DEPTH) - 32'(occ_after);

  assign hdr_good = (hdr.sync == SYNC_WORD) &&
                    (hdr.len != 16'd0) &&
                    (32'(hdr.len) <= 32'((RS_CNT - 1) * 8)) &&
                    !s_axis_input.tlast;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    last_keep_d = last_keep_q;
    exp_seq_d   = exp_seq_q;
    ok_cnt_d    = ok_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    hdr_err_d   = 1'b0;
    seq_gap_d   = 1'b0;
    wr_en       = 1'b0;
    wr_keep     = 8'hFF;
    wr_last     = 1'b0;

    unique case (state_q)
      HDR: begin
        if (beat) begin
          if (!hdr_good) begin
            hdr_err_d  = 1'b1;
            drop_cnt_d = drop_cnt_q + 16'd1;
            state_d    = s_axis_input.tlast ? HDR : DISCARD;
          end else begin
            seq_gap_d = (hdr.seq != exp_seq_q);
            // Whole-frame admission: never start a frame the FIFO cannot hold.
            if (free_entries < 32'(nbeats)) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
              state_d    = DISCARD;
            end else begin
              rem_d       = nbeats;
              last_keep_d = calc_tkeep(hdr.len[2:0]);
              exp_seq_d   = hdr.seq + 16'd1;
              state_d     = PAYLOAD;
            end
          end
        end
      end

      PAYLOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (rem_q == 14'd1) begin
            wr_keep  = last_keep_q;
            wr_last  = 1'b1;
            ok_cnt_d = ok_cnt_q + 16'd1;
            state_d  = s_axis_input.tlast ? HDR : DISCARD;
          end else if (s_axis_input.tlast) begin
            // Truncated block: close the packet so downstream stays framed.
            wr_last    = 1'b1;
            drop_cnt_d = drop_cnt_q + 16'd1;
            state_d    = HDR;
          end else begin
            rem_d = rem_q - 14'd1;
          end
        end
      end

      DISCARD: begin
        if (beat && s_axis_input.tlast) state_d = HDR;
      end

      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HDR;
      rem_q       <= '0;
      last_keep_q <= 8'hFF;
      exp_seq_q   <= '0;
      ok_cnt_q    <= '0;
      drop_cnt_q  <= '0;
      hdr_err_q   <= 1'b0;
      seq_gap_q   <= 1'b0;
      tready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      last_keep_q <= last_keep_d;
      exp_seq_q   <= exp_seq_d;
      ok_cnt_q    <= ok_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      hdr_err_q   <= hdr_err_d;
      seq_gap_q   <= seq_gap_d;
      tready_q    <= 1'b1;
    end
  end

  mac_rx_fifo #(
    .WIDTH (73),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .wr_en   (wr_en),
    .wr_data ({wr_last, wr_keep, s_axis_input.tdata}),
    .rd_en   (m_axis_output.tready),
    .rd_data (rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign s_axis_input.tready  = tready_q;
  assign m_axis_output.tvalid = !fifo_empty;
  assign m_axis_output.tdata  = rd_data[63:0];
  assign m_axis_output.tkeep  = rd_data[71:64];
  assign m_axis_output.tlast  = rd_data[72];

  assign frame_ok_cnt   = ok_cnt_q;
  assign frame_drop_cnt = drop_cnt_q;
  assign hdr_err        = hdr_err_q;
  assign seq_gap        = seq_gap_q;

endmodule

// File: tb/tb_mac_deframer.sv
`timescale 1ns/1ps
module tb_mac_deframer;
  localparam int          RS   = 236;
  localparam logic [31:0] SYNC = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_drop_cnt;
  logic        hdr_err;
  logic        seq_gap;

  mac_deframer_if s_if();
  mac_deframer_if m_if();

  mac_deframer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_axis_input   (s_if),
    .m_axis_output  (m_if),
    .frame_ok_cnt   (frame_ok_cnt),
    .frame_drop_cnt (frame_drop_cnt),
    .hdr_err        (hdr_err),
    .seq_gap        (seq_gap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hdr_err_n = 0;
  int seq_gap_n = 0;
  logic [72:0] out_q[$];

  always @(negedge clk) begin
    if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1)
      out_q.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
    if (hdr_err === 1'b1) hdr_err_n++;
    if (seq_gap === 1'b1) seq_gap_n++;
  end

  function automatic logic [63:0] mk_hdr(input logic [31:0] sync, input logic [15:0] len,
                                         input logic [15:0] seq);
    return {seq, len, sync};
  endfunction

  function automatic logic [63:0] body_word(input int seed, input int idx);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'((seed + idx * 8 + j) & 255);
    return w;
  endfunction

  task automatic drive_beat(input logic [63:0] data, input logic last);
    s_if.tvalid = 1'b1;
    s_if.tdata  = data;
    s_if.tlast  = last;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_block(input logic [63:0] hdr, input int seed, input int nbody);
    drive_beat(hdr, 1'b0);
    for (int i = 0; i < nbody; i++) drive_beat(body_word(seed, i), (i == nbody - 1));
    idle(1);
  endtask

  task automatic apply_reset(input logic rdy);
    reset_n     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = rdy;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    out_q.delete();
    hdr_err_n = 0;
    seq_gap_n = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = 8'hFF;
    m_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_if.tready !== 1'b0) begin failures++; $display("FAIL rst_in_tready got=%b exp=0", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL rst_out_tvalid got=%b exp=0", m_if.tvalid); end
    checks++; if ({frame_ok_cnt, frame_drop_cnt} !== 32'h0) begin failures++; $display("FAIL rst_counters got=%h exp=0", {frame_ok_cnt, frame_drop_cnt}); end
    checks++; if ({hdr_err, seq_gap} !== 2'b00) begin failures++; $display("FAIL rst_pulses got=%b exp=00", {hdr_err, seq_gap}); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_if.tready !== 1'b1) begin failures++; $display("FAIL post_rst_tready got=%b exp=1", s_if.tready); end
  endtask

  task automatic test_good_frame();
    logic [72:0] w;
    apply_reset(1'b1);
    send_block(mk_hdr(SYNC, 16'd20, 16'd0), 3, RS - 1);
    idle(6);
    checks++; if (out_q.size() != 3) begin failures++; $display("FAIL good_beats got=%0d exp=3", out_q.size()); end
    for (int k = 0; k < 3 && k < out_q.size(); k++) begin
      w = out_q[k];
      checks++; if (w[63:0] !== body_word(3, k)) begin failures++; $display("FAIL good_data%0d got=%h exp=%h", k, w[63:0], body_word(3, k)); end
      checks++; if (w[71:64] !== ((k < 2) ? 8'hFF : 8'h0F)) begin failures++; $display("FAIL good_keep%0d got=%h exp=%h", k, w[71:64], (k < 2) ? 8'hFF : 8'h0F); end
      checks++; if (w[72] !== (k == 2)) begin failures++; $display("FAIL good_last%0d got=%b exp=%b", k, w[72], (k == 2)); end
    end
    checks++; if (frame_ok_cnt !== 16'd1) begin failures++; $display("FAIL good_ok_cnt got=%0d exp=1", frame_ok_cnt); end
    checks++; if (frame_drop_cnt !== 16'd0) begin failures++; $display("FAIL good_drop_cnt got=%0d exp=0", frame_drop_cnt); end
    checks++; if (hdr_err_n + seq_gap_n != 0) begin failures++; $display("FAIL good_pulses got=%0d exp=0", hdr_err_n + seq_gap_n); end
  endtask

  task automatic test_latency();
    apply_reset(1'b0);
    drive_beat(mk_hdr(SYNC, 16'd8, 16'd0), 1'b0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = body_word(5, 0);
    s_if.tlast  = 1'b0;
    checks++; if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL lat_pre_valid got=%b exp=0", m_if.tvalid); end
    @(posedge clk); #1;
    checks++; if (m_if.tvalid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b exp=1", m_if.tvalid); end
    checks++; if ({m_if.tlast, m_if.tkeep, m_if.tdata} !== {1'b1, 8'hFF, body_word(5, 0)}) begin
      failures++; $display("FAIL lat_beat got=%h exp=%h", {m_if.tlast, m_if.tkeep, m_if.tdata}, {1'b1, 8'hFF, body_word(5, 0)});
    end
    for (int i = 1; i < RS - 1; i++) drive_beat(body_word(5, i), (i == RS - 2));
    idle(1);
    checks++; if (m_if.tdata !== body_word(5, 0)) begin failures++; $display("FAIL lat_hold got=%h exp=%h", m_if.tdata, body_word(5, 0)); end
    m_if.tready = 1'b1;
    idle(4);
    checks++; if (out_q.size() != 1 || frame_ok_cnt !== 16'd1) begin
      failures++; $display("FAIL lat_drain got=%0d/%0d exp=1/1", out_q.size(), frame_ok_cnt);
    end
  endtask

  task automatic test_bad_sync();
    logic [72:0] w;
    apply_reset(1'b1);
    send_block(mk_hdr(32'hDEADBEEF, 16'd20, 16'd0), 1, RS - 1);
    idle(3);
    checks++; if (out_q.size() != 0) begin failures++; $display("FAIL badsync_emit got=%0d exp=0", out_q.size()); end
    send_block(mk_hdr(SYNC, 16'd20, 16'd0), 7, RS - 1);
    idle(6);
    checks++; if (hdr_err_n != 1) begin failures++; $display("FAIL badsync_hdr_err got=%0d exp=1", hdr_err_n); end
    checks++; if (frame_drop_cnt !== 16'd1) begin failures++; $display("FAIL badsync_drop got=%0d exp=1", frame_drop_cnt); end
    checks++; if (frame_ok_cnt !== 16'd1) begin failures++; $display("FAIL badsync_ok got=%0d exp=1", frame_ok_cnt); end
    checks++; if (out_q.size() != 3) begin failures++; $display("FAIL badsync_beats got=%0d exp=3", out_q.size()); end
    if (out_q.size() == 3) begin
      w = out_q[2];
      checks++; if (w !== {1'b1, 8'h0F, body_word(7, 2)}) begin failures++; $display("FAIL badsync_last got=%h exp=%h", w, {1'b1, 8'h0F, body_word(7, 2)}); end
    end
  endtask

  task automatic test_len_bounds();
    logic [72:0] w;
    apply_reset(1'b1);
    send_block(mk_hdr(SYNC, 16'd0, 16'd0), 1, RS - 1);
    send_block(mk_hdr(SYNC, 16'd1881, 16'd0), 1, RS - 1);
    idle(3);
    checks++; if (hdr_err_n != 2) begin failures++; $display("FAIL len_hdr_err got=%0d exp=2", hdr_err_n); end
    checks++; if (frame_drop_cnt !== 16'd2) begin failures++; $display("FAIL len_drop got=%0d exp=2", frame_drop_cnt); end
    checks++; if (out_q.size() != 0) begin failures++; $display("FAIL len_emit got=%0d exp=0", out_q.size()); end
    send_block(mk_hdr(SYNC, 16'd1, 16'd0), 9, RS - 1);
    idle(3);
    checks++; if (out_q.size() != 1) begin failures++; $display("FAIL len1_beats got=%0d exp=1", out_q.size()); end
    if (out_q.size() == 1) begin
      w = out_q[0];
      checks++; if (w !== {1'b1, 8'h01, body_word(9, 0)}) begin failures++; $display("FAIL len1_beat got=%h exp=%h", w, {1'b1, 8'h01, body_word(9, 0)}); end
    end
  endtask

  task automatic test_seq_gap();
    logic [72:0] w;
    apply_reset(1'b1);
    send_block(mk_hdr(SYNC, 16'd8, 16'd0), 1, RS - 1);
    send_block(mk_hdr(SYNC, 16'd16, 16'd1), 2, RS - 1);
    idle(2);
    checks++; if (seq_gap_n != 0) begin failures++; $display("FAIL seq_in_order got=%0d exp=0", seq_gap_n); end
    send_block(mk_hdr(SYNC, 16'd9, 16'd3), 4, RS - 1);
    idle(4);
    checks++; if (seq_gap_n != 1) begin failures++; $display("FAIL seq_gap_cnt got=%0d exp=1", seq_gap_n); end
    checks++; if (frame_ok_cnt !== 16'd3) begin failures++; $display("FAIL seq_ok got=%0d exp=3", frame_ok_cnt); end
    checks++; if (out_q.size() != 5) begin failures++; $display("FAIL seq_beats got=%0d exp=5", out_q.size()); end
    if (out_q.size() == 5) begin
      w = out_q[4];
      checks++; if (w !== {1'b1, 8'h01, body_word(4, 1)}) begin failures++; $display("FAIL seq_last got=%h exp=%h", w, {1'b1, 8'h01, body_word(4, 1)}); end
      w = out_q[3];
      checks++; if (w !== {1'b0, 8'hFF, body_word(4, 0)}) begin failures++; $display("FAIL seq_first got=%h exp=%h", w, {1'b0, 8'hFF, body_word(4, 0)}); end
    end
  endtask

  task automatic test_backpressure();
    int errs;
    logic [72:0] w;
    logic [72:0] exp_w;
    apply_reset(1'b0);
    send_block(mk_hdr(SYNC, 16'd1880, 16'd0), 11, RS - 1);
    send_block(mk_hdr(SYNC, 16'd1880, 16'd1), 12, RS - 1);
    send_block(mk_hdr(SYNC, 16'd1880, 16'd2), 13, RS - 1);
    idle(2);
    checks++; if (frame_drop_cnt !== 16'd1) begin failures++; $display("FAIL bp_drop got=%0d exp=1", frame_drop_cnt); end
    checks++; if (frame_ok_cnt !== 16'd2) begin failures++; $display("FAIL bp_ok got=%0d exp=2", frame_ok_cnt); end
    checks++; if (m_if.tvalid !== 1'b1 || out_q.size() != 0) begin failures++; $display("FAIL bp_hold got=%b/%0d exp=1/0", m_if.tvalid, out_q.size()); end
    m_if.tready = 1'b1;
    idle(480);
    checks++; if (out_q.size() != 470) begin failures++; $display("FAIL bp_drain got=%0d exp=470", out_q.size()); end
    errs = 0;
    for (int k = 0; k < out_q.size() && k < 470; k++) begin
      w = out_q[k];
      exp_w = {((k % 235) == 234), 8'hFF, body_word((k < 235) ? 11 : 12, k % 235)};
      if (w !== exp_w) errs++;
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL bp_data got=%0d bad beats exp=0", errs); end
    checks++; if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", m_if.tvalid); end
  endtask

  task automatic test_trunc_reset();
    int errs;
    logic [72:0] w;
    apply_reset(1'b0);
    send_block(mk_hdr(SYNC, 16'd200, 16'd0), 21, 10);
    idle(2);
    checks++; if (frame_drop_cnt !== 16'd1 || frame_ok_cnt !== 16'd0) begin
      failures++; $display("FAIL trunc_counts got=%0d/%0d exp=1/0", frame_drop_cnt, frame_ok_cnt);
    end
    m_if.tready = 1'b1;
    idle(14);
    checks++; if (out_q.size() != 10) begin failures++; $display("FAIL trunc_beats got=%0d exp=10", out_q.size()); end
    errs = 0;
    for (int k = 0; k < out_q.size() && k < 10; k++) begin
      w = out_q[k];
      if (w !== {(k == 9), 8'hFF, body_word(21, k)}) errs++;
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL trunc_data got=%0d bad beats exp=0", errs); end
    out_q.delete();
    m_if.tready = 1'b0;
    send_block(mk_hdr(SYNC, 16'd80, 16'd1), 31, 10);
    m_if.tready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    m_if.tready = 1'b0;
    checks++; if (out_q.size() != 3) begin failures++; $display("FAIL mid_drain got=%0d exp=3", out_q.size()); end
    reset_n = 1'b0;
    #2;
    checks++; if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin
      failures++; $display("FAIL mid_rst got=%b%b exp=00", m_if.tvalid, s_if.tready);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_if.tready = 1'b1;
    idle(30);
    checks++; if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%b exp=0", m_if.tvalid); end
    checks++; if ({frame_ok_cnt, frame_drop_cnt} !== 32'h0) begin failures++; $display("FAIL post_rst_cnt got=%h exp=0", {frame_ok_cnt, frame_drop_cnt}); end
    checks++; if (out_q.size() != 3) begin failures++; $display("FAIL post_rst_emit got=%0d exp=3", out_q.size()); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_latency();
    test_bad_sync();
    test_len_bounds();
    test_seq_gap();
    test_backpressure();
    test_trunc_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
